// File: rtl/dsp_pkg.sv
// Carry-in source encodings and helpers shared by the DSP48E1 carry-in datapath.
// Pure definitions: no latency, no flow control.
package dsp_pkg;

  typedef enum logic [2:0] {
    SEL_CARRYIN = 3'b000,
    SEL_NPCIN   = 3'b001,
    SEL_CASCIN  = 3'b010,
    SEL_PCIN    = 3'b011,
    SEL_CASCOUT = 3'b100,
    SEL_NP      = 3'b101,
    SEL_RND     = 3'b110,
    SEL_P       = 3'b111
  } cinsel_e;

  // Sources that loop back from this slice's own outputs.
  function automatic logic is_feedback(input logic [2:0] sel);
    return (sel == SEL_CASCOUT) || (sel == SEL_NP) || (sel == SEL_P);
  endfunction

endpackage

// File: rtl/cin_pipe.sv
// CE-gated, synchronously cleared shift register of DEPTH stages (0 = wire); latency DEPTH enabled cycles.
// No backpressure: ce low holds every stage, reset clears all stages regardless of ce.
module cin_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, ce};
      assign q = d;
    end else begin : g_reg
      logic [WIDTH-1:0] stg [DEPTH];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
        end else if (ce) begin
          stg[0] <= d;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/cin_sel_pipe.sv
// DSP48E1 carry-in selector: 8-way CIN decode over a CIN_STAGES-deep CARRYIN pipe, optional sel/rnd regs.
// CIN is combinational after the registers; ILLEGAL_SEL lags the effective select by one cycle; CEs only hold state.
module cin_sel_pipe
  import dsp_pkg::*;
#(
  parameter int CIN_STAGES = 1,
  parameter int SEL_REG    = 1,
  parameter int RND_REG    = 1,
  parameter int PREG       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CECARRYIN,
  input  logic       CECTRL,
  input  logic       CEM,
  input  logic       CARRYIN,
  input  logic       CARRYCASCIN,
  input  logic       CARRYCASCOUT,
  input  logic       PCIN_MSB,
  input  logic       P_MSB,
  input  logic       A_SIGN,
  input  logic       B_SIGN,
  input  logic [2:0] CARRYINSEL,
  output logic       CIN,
  output logic       ILLEGAL_SEL
);

  localparam int SEL_DEPTH = (SEL_REG != 0) ? 1 : 0;
  localparam int RND_DEPTH = (RND_REG != 0) ? 1 : 0;

  logic [2:0] sel_q;
  logic       carry_q;
  logic       rnd_d;
  logic       rnd_q;
  logic       illegal_d;
  logic       illegal_q;

  cin_pipe #(.DEPTH(CIN_STAGES), .WIDTH(1)) u_carry_pipe (
    .clk (clk),
    .rst (rst),
    .ce  (CECARRYIN),
    .d   (CARRYIN),
    .q   (carry_q)
  );

  cin_pipe #(.DEPTH(SEL_DEPTH), .WIDTH(3)) u_sel_reg (
    .clk (clk),
    .rst (rst),
    .ce  (CECTRL),
    .d   (CARRYINSEL),
    .q   (sel_q)
  );

  // Symmetric-rounding term, aligned with the multiplier register when RND_REG=1.
  assign rnd_d = ~(A_SIGN ^ B_SIGN);

  cin_pipe #(.DEPTH(RND_DEPTH), .WIDTH(1)) u_rnd_reg (
    .clk (clk),
    .rst (rst),
    .ce  (CEM),
    .d   (rnd_d),
    .q   (rnd_q)
  );

  // Without a P register, feedback sources would close a combinational loop.
  assign illegal_d = (PREG == 0) && is_feedback(sel_q);

  always_comb begin
    CIN = 1'b0;
    case (sel_q)
      SEL_CARRYIN: CIN = carry_q;
      SEL_NPCIN:   CIN = ~PCIN_MSB;
      SEL_CASCIN:  CIN = CARRYCASCIN;
      SEL_PCIN:    CIN = PCIN_MSB;
      SEL_CASCOUT: CIN = CARRYCASCOUT;
      SEL_NP:      CIN = ~P_MSB;
      SEL_RND:     CIN = rnd_q;
      SEL_P:       CIN = P_MSB;
      default:     CIN = 1'b0;
    endcase
    if (illegal_d) CIN = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end

  assign ILLEGAL_SEL = illegal_q;

endmodule

// File: tb/tb_cin_sel_pipe.sv
// Directed bench for cin_sel_pipe: three instances (2-stage/PREG=1, 2-stage/PREG=0, all-bypass) on shared stimulus.
module tb_cin_sel_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       CECARRYIN, CECTRL, CEM;
  logic       CARRYIN, CARRYCASCIN, CARRYCASCOUT, PCIN_MSB, P_MSB, A_SIGN, B_SIGN;
  logic [2:0] CARRYINSEL;
  logic       cin_a, cin_b, cin_c, ill_a, ill_b, ill_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cin_sel_pipe #(.CIN_STAGES(2), .SEL_REG(1), .RND_REG(1), .PREG(1)) u_a (
    .clk(clk), .rst(rst), .CECARRYIN(CECARRYIN), .CECTRL(CECTRL), .CEM(CEM),
    .CARRYIN(CARRYIN), .CARRYCASCIN(CARRYCASCIN), .CARRYCASCOUT(CARRYCASCOUT),
    .PCIN_MSB(PCIN_MSB), .P_MSB(P_MSB), .A_SIGN(A_SIGN), .B_SIGN(B_SIGN),
    .CARRYINSEL(CARRYINSEL), .CIN(cin_a), .ILLEGAL_SEL(ill_a));

  cin_sel_pipe #(.CIN_STAGES(2), .SEL_REG(1), .RND_REG(1), .PREG(0)) u_b (
    .clk(clk), .rst(rst), .CECARRYIN(CECARRYIN), .CECTRL(CECTRL), .CEM(CEM),
    .CARRYIN(CARRYIN), .CARRYCASCIN(CARRYCASCIN), .CARRYCASCOUT(CARRYCASCOUT),
    .PCIN_MSB(PCIN_MSB), .P_MSB(P_MSB), .A_SIGN(A_SIGN), .B_SIGN(B_SIGN),
    .CARRYINSEL(CARRYINSEL), .CIN(cin_b), .ILLEGAL_SEL(ill_b));

  cin_sel_pipe #(.CIN_STAGES(0), .SEL_REG(0), .RND_REG(0), .PREG(1)) u_c (
    .clk(clk), .rst(rst), .CECARRYIN(CECARRYIN), .CECTRL(CECTRL), .CEM(CEM),
    .CARRYIN(CARRYIN), .CARRYCASCIN(CARRYCASCIN), .CARRYCASCOUT(CARRYCASCOUT),
    .PCIN_MSB(PCIN_MSB), .P_MSB(P_MSB), .A_SIGN(A_SIGN), .B_SIGN(B_SIGN),
    .CARRYINSEL(CARRYINSEL), .CIN(cin_c), .ILLEGAL_SEL(ill_c));

  typedef struct {
    logic [2:0] sel;
    logic       exp_a;    // PREG=1 CIN
    logic       exp_b;    // PREG=0 CIN (feedback forced low)
    logic       exp_ill;  // PREG=0 illegal flag for this select
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow after settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic prev_ill;

    vecs[0] = '{3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'b010, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'b011, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{3'b100, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{3'b101, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{3'b110, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{3'b111, 1'b0, 1'b0, 1'b1};

    rst = 1'b0; CECARRYIN = 1'b0; CECTRL = 1'b1; CEM = 1'b0;
    CARRYIN = 1'b0; CARRYCASCIN = 1'b0; CARRYCASCOUT = 1'b0;
    PCIN_MSB = 1'b0; P_MSB = 1'b0; A_SIGN = 1'b0; B_SIGN = 1'b0;
    CARRYINSEL = 3'b000;

    // Reset state
    tick(); tick();
    rst = 1'b1;
    settle();
    chk("reset_cin_a", cin_a, 1'b0);
    chk("reset_cin_b", cin_b, 1'b0);
    chk("reset_ill_a", ill_a, 1'b0);
    chk("reset_ill_b", ill_b, 1'b0);
    chk("reset_cin_c", cin_c, 1'b0);

    // Single-cycle CARRYIN pulse through a 2-stage pipe
    tick();
    CARRYIN = 1'b1; CECARRYIN = 1'b1;
    settle();
    chk("bypass_carry_hi", cin_c, 1'b1);
    chk("pulse_pre_edge", cin_a, 1'b0);
    tick();
    CARRYIN = 1'b0;
    settle();
    chk("pulse_c1", cin_a, 1'b0);
    chk("bypass_carry_lo", cin_c, 1'b0);
    tick(); chk("pulse_c2_a", cin_a, 1'b1); chk("pulse_c2_b", cin_b, 1'b1);
    tick(); chk("pulse_c3", cin_a, 1'b0);

    // Pulse with 3 stalled cycles mid-flight
    CARRYIN = 1'b1;
    tick();
    CARRYIN = 1'b0; CECARRYIN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_hold", cin_a, 1'b0);
    end
    CECARRYIN = 1'b1;
    tick(); chk("stall_arrive", cin_a, 1'b1);
    tick(); chk("stall_after", cin_a, 1'b0);

    // Select sweep
    PCIN_MSB = 1'b1; P_MSB = 1'b0; CARRYCASCIN = 1'b1; CARRYCASCOUT = 1'b1;
    A_SIGN = 1'b1; B_SIGN = 1'b1; CEM = 1'b1; CARRYIN = 1'b0;
    CARRYINSEL = 3'b000;
    tick(); tick();
    prev_ill = 1'b0;
    for (int k = 0; k < 8; k++) begin
      CARRYINSEL = vecs[k].sel;
      settle();
      chk("sweep_c_comb", cin_c, vecs[k].exp_a);
      tick();
      chk("sweep_cin_a", cin_a, vecs[k].exp_a);
      chk("sweep_cin_b", cin_b, vecs[k].exp_b);
      chk("sweep_ill_b", ill_b, prev_ill);
      chk("sweep_ill_a", ill_a, 1'b0);
      chk("sweep_ill_c", ill_c, 1'b0);
      prev_ill = vecs[k].exp_ill;
    end

    // Illegal feedback select with PREG=0, then back to a legal one
    CARRYINSEL = 3'b010;
    tick(); tick();
    chk("ill_idle", ill_b, 1'b0);
    CARRYINSEL = 3'b100;
    tick();
    chk("ill_cin_forced", cin_b, 1'b0);
    chk("ill_cin_a_cascout", cin_a, 1'b1);
    chk("ill_not_yet", ill_b, 1'b0);
    tick(); chk("ill_set", ill_b, 1'b1);
    tick(); chk("ill_stays", ill_b, 1'b1);
    CARRYINSEL = 3'b010;
    tick();
    chk("ill_legal_cin", cin_b, 1'b1);
    chk("ill_still_set", ill_b, 1'b1);
    tick(); chk("ill_clear", ill_b, 1'b0);

    // Registered rounding term under CEM
    CARRYINSEL = 3'b110; A_SIGN = 1'b0; B_SIGN = 1'b1; CEM = 1'b1;
    settle(); chk("rnd_comb_0", cin_c, 1'b0);
    tick(); chk("rnd_reg_0", cin_a, 1'b0);
    A_SIGN = 1'b1; CEM = 1'b0;
    settle(); chk("rnd_comb_1", cin_c, 1'b1);
    tick(); chk("rnd_hold", cin_a, 1'b0);
    CEM = 1'b1;
    tick(); chk("rnd_reg_1", cin_a, 1'b1);

    // All CEs low: held select still tracks live sources
    CARRYINSEL = 3'b011;
    tick();
    CECTRL = 1'b0; CEM = 1'b0; CECARRYIN = 1'b0; CARRYINSEL = 3'b000; PCIN_MSB = 1'b0;
    settle(); chk("ce_low_pcin0", cin_a, 1'b0);
    PCIN_MSB = 1'b1;
    settle(); chk("ce_low_pcin1", cin_a, 1'b1);
    tick(); chk("ce_low_sel_held", cin_a, 1'b1);

    // Reset mid-pipeline with stages full and CECARRYIN low
    CECTRL = 1'b1; CECARRYIN = 1'b1; CARRYIN = 1'b1;
    tick(); tick();
    chk("full_pipe", cin_a, 1'b1);
    CECARRYIN = 1'b0; CARRYIN = 1'b0; CARRYINSEL = 3'b100;
    tick(); tick();
    chk("pre_rst_ill", ill_b, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1; CECTRL = 1'b0;
    settle();
    chk("rst_mid_cin_a", cin_a, 1'b0);
    chk("rst_mid_cin_b", cin_b, 1'b0);
    chk("rst_mid_ill_b", ill_b, 1'b0);
    CECARRYIN = 1'b1;
    tick(); chk("rst_flush_1", cin_a, 1'b0);
    tick(); chk("rst_flush_2", cin_a, 1'b0);
    chk("rst_ill_after", ill_b, 1'b0);

    // Fully combinational instance: no clocked dependence
    CARRYINSEL = 3'b000; CARRYIN = 1'b1;
    settle(); chk("comb_carry_1", cin_c, 1'b1);
    CARRYIN = 1'b0;
    settle(); chk("comb_carry_0", cin_c, 1'b0);
    CARRYINSEL = 3'b011; PCIN_MSB = 1'b0;
    settle(); chk("comb_pcin_0", cin_c, 1'b0);
    CARRYINSEL = 3'b001;
    settle(); chk("comb_npcin", cin_c, 1'b1);
    CARRYINSEL = 3'b101; P_MSB = 1'b0;
    settle(); chk("comb_np", cin_c, 1'b1);
    CARRYINSEL = 3'b111;
    settle(); chk("comb_p", cin_c, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
